// File: rtl/fnv1a_lane_reduce.sv
// FNV-1a lane reducer: folds WORDS_PER_LANE mix words per lane into one 32-bit hash
// and hands each lane hash, tagged with its lane index, to the digest stage.
`timescale 1ns/1ps

module fnv1a_lane_reduce #(
    parameter int unsigned WORDS_PER_LANE = 32,
    parameter int unsigned LANES          = 16,
    parameter logic [31:0] FNV_OFFSET     = 32'h811C9DC5,
    parameter logic [31:0] FNV_PRIME      = 32'h01000193,
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int unsigned WW = (WORDS_PER_LANE > 1) ? $clog2(WORDS_PER_LANE) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic [LW-1:0] out_lane,
    output logic          out_last
);

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_t;

    localparam logic [WW-1:0] WORD_MAX = WW'(WORDS_PER_LANE - 1);
    localparam logic [LW-1:0] LANE_MAX = LW'(LANES - 1);

    state_t         r_state;
    state_t         w_state_next;
    logic [31:0]    r_hash;
    logic [WW-1:0]  r_word_cnt;
    logic [LW-1:0]  r_lane_cnt;
    logic           r_out_valid;
    logic [31:0]    r_out_data;
    logic [LW-1:0]  r_out_lane;
    logic           r_out_last;

    logic [31:0]    w_next_h;
    logic           w_accept;
    logic           w_last_word;
    logic           w_lane_last;
    logic           w_out_hs;

    assign in_ready  = (r_state == ACCUM) && !rst;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_lane  = r_out_lane;
    assign out_last  = r_out_last;

    // Product is taken modulo 2^32 by the 32-bit assignment.
    assign w_next_h    = (r_hash ^ in_data) * FNV_PRIME;
    assign w_accept    = in_valid && in_ready;
    assign w_last_word = (r_word_cnt == WORD_MAX);
    assign w_lane_last = (r_lane_cnt == LANE_MAX);
    assign w_out_hs    = r_out_valid && out_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACCUM:   if (w_accept && w_last_word) w_state_next = OUT;
            OUT:     if (w_out_hs) w_state_next = ACCUM;
            default: w_state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ACCUM;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hash      <= FNV_OFFSET;
            r_word_cnt  <= '0;
            r_lane_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_lane  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_last_word) begin
                    r_out_data  <= w_next_h;
                    r_out_lane  <= r_lane_cnt;
                    r_out_last  <= w_lane_last;
                    r_out_valid <= 1'b1;
                    r_word_cnt  <= '0;
                    r_hash      <= FNV_OFFSET;
                end else begin
                    r_hash     <= w_next_h;
                    r_word_cnt <= r_word_cnt + 1'b1;
                end
            end
            // Only reachable in OUT, so it never coincides with an accept.
            if (w_out_hs) begin
                r_out_valid <= 1'b0;
                r_lane_cnt  <= w_lane_last ? '0 : r_lane_cnt + 1'b1;
            end
        end
    end

endmodule
